// File: rtl/dsm_sample_scheduler.sv
// dsm_sample_scheduler: buffers low-rate PCM samples in a small FIFO and
// replays each one as OSR zero-order-held update beats to the delta-sigma
// modulator, one beat per divider tick. Starvation repeats the held sample.
module dsm_sample_scheduler #(
  parameter int WIDTH      = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int OSR_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 aclk,
  input  logic                 arst,
  input  logic                 cfg_enable,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [OSR_WIDTH-1:0] cfg_osr,
  input  logic [WIDTH-1:0]     s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [WIDTH-1:0]     m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready,
  output logic                 busy,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt,
  output logic                 late
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [OSR_WIDTH-1:0] OSR_ONE  = OSR_WIDTH'(1);
  localparam logic [15:0]          CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
  logic [OSR_WIDTH-1:0]  osr_q, osr_d, beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0]      hold_q, hold_d, tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tready_q, tready_d, busy_q, busy_d;
  logic                  underrun_q, underrun_d, late_q, late_d;
  logic [15:0]           ucnt_q, ucnt_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic                  wr_en, rd_en, flush, tick, pending, fifo_empty;

  // Next-state logic: sequencing FSM, divider/beat counters, FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    osr_d      = osr_q;
    div_cnt_d  = div_cnt_q;
    beat_cnt_d = beat_cnt_q;
    hold_d     = hold_q;
    tdata_d    = tdata_q;
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    late_d     = late_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_en      = 1'b0;
    flush      = 1'b0;
    fifo_empty = (count_q == '0);
    wr_en      = s_axis_data_tvalid && tready_q;
    tick       = (div_cnt_q == (div_q - DIV_ONE));
    // A beat accepted this cycle frees the slot for a same-cycle tick.
    pending    = tvalid_q && !m_axis_data_tready;
    tvalid_d   = pending;

    if (!cfg_enable) begin
      state_d  = IDLE;
      flush    = 1'b1;
      tvalid_d = 1'b0;
      hold_d   = '0;
      tdata_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          flush      = 1'b1;
          tvalid_d   = 1'b0;
          hold_d     = '0;
          state_d    = PRIME;
          div_d      = (cfg_div == '0) ? DIV_ONE : cfg_div;
          osr_d      = (cfg_osr == '0) ? OSR_ONE : cfg_osr;
          underrun_d = 1'b0;
          ucnt_d     = 16'h0000;
          late_d     = 1'b0;
        end
        PRIME: begin
          div_cnt_d  = '0;
          beat_cnt_d = '0;
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            state_d = RUN;
          end else begin
            state_d = PRIME;
          end
        end
        RUN: begin
          if (tick) begin
            div_cnt_d = '0;
            if (pending) begin
              // Dropped tick: keep the pending beat intact and flag lateness.
              late_d = 1'b1;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = hold_q;
              if (beat_cnt_q == (osr_q - OSR_ONE)) begin
                beat_cnt_d = '0;
                if (!fifo_empty) begin
                  rd_en  = 1'b1;
                  hold_d = mem_q[rd_ptr_q];
                end else begin
                  underrun_d = 1'b1;
                  ucnt_d     = (ucnt_q == CNT_MAX) ? CNT_MAX : (ucnt_q + 16'h0001);
                end
              end else begin
                beat_cnt_d = beat_cnt_q + OSR_ONE;
              end
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
          end
        end
        default: begin
          state_d  = IDLE;
          flush    = 1'b1;
          tvalid_d = 1'b0;
        end
      endcase
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d  = count_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
    end

    busy_d   = (state_d != IDLE);
    tready_d = busy_d && (count_d != FULL_CNT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      osr_q      <= '0;
      div_cnt_q  <= '0;
      beat_cnt_q <= '0;
      hold_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= 16'h0000;
      late_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      osr_q      <= osr_d;
      div_cnt_q  <= div_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      hold_q     <= hold_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tready_q   <= tready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
      late_q     <= late_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s_axis_data_tdata;
    end
  end

  assign s_axis_data_tready = tready_q;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = tvalid_q;
  assign busy               = busy_q;
  assign underrun           = underrun_q;
  assign underrun_cnt       = ucnt_q;
  assign late               = late_q;

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Directed self-checking bench for dsm_sample_scheduler.
module tb_dsm_sample_scheduler;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_div = 16'h0000;
  logic [15:0] cfg_osr = 16'h0000;
  logic [15:0] s_tdata = 16'h0000;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy, underrun, late;
  logic [15:0] ucnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  logic [15:0] src [0:15];
  int src_idx = 0;
  int src_n = 0;
  logic [15:0] beat_d [$];
  int beat_t [$];
  int n;
  int seen;

  always #5 aclk = ~aclk;

  dsm_sample_scheduler dut (
    .aclk(aclk), .arst(arst), .cfg_enable(cfg_enable),
    .cfg_div(cfg_div), .cfg_osr(cfg_osr),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .busy(busy), .underrun(underrun), .underrun_cnt(ucnt), .late(late)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (src_idx < src_n) begin
      s_tvalid = 1'b1;
      s_tdata  = src[src_idx];
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 16'h0000;
    end
  endtask

  // One clock: account handshakes seen before the edge, then step past it.
  task automatic cyc();
    if (s_tvalid && s_tready) src_idx++;
    if (m_tvalid && m_tready) begin
      beat_d.push_back(m_tdata);
      beat_t.push_back(cyc_n);
    end
    @(posedge aclk);
    #1;
    cyc_n++;
    drive_src();
  endtask

  task automatic wait_valid(input string tag, input int bound, output int cnt);
    cnt = 0;
    while (!m_tvalid && cnt < bound) begin
      cyc();
      cnt++;
    end
    chk(tag, {31'd0, m_tvalid}, 32'd1);
  endtask

  task automatic collect(input string tag, input int nb, input int bound);
    int k = 0;
    while (beat_d.size() < nb && k < bound) begin
      cyc();
      k++;
    end
    chk(tag, beat_d.size(), nb);
  endtask

  // Return to IDLE, then arm the source with nsrc samples and request a run.
  task automatic restart(input logic [15:0] d, input logic [15:0] o, input int nsrc);
    cfg_enable = 1'b0;
    src_n   = 0;
    src_idx = 0;
    cyc();
    src_n   = nsrc;
    drive_src();
    cfg_div = d;
    cfg_osr = o;
    beat_d.delete();
    beat_t.delete();
    cfg_enable = 1'b1;
  endtask

  initial begin
    // Reset values
    cyc();
    cyc();
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ucnt", {16'd0, ucnt}, 32'd0);
    chk("rst_late", {31'd0, late}, 32'd0);
    arst = 1'b0;

    // Test 1: ramp 1..8, div=4, osr=3, always ready
    for (int i = 0; i < 8; i++) src[i] = 16'(i + 1);
    restart(16'd4, 16'd3, 8);
    wait_valid("t1_first_beat", 40, n);
    chk("t1_latency", n, 7);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    collect("t1_b23", 23, 200);
    chk("t1_no_underrun", {31'd0, underrun}, 32'd0);
    collect("t1_b24", 24, 40);
    for (int i = 0; i < 24; i++) chk("t1_data", {16'd0, beat_d[i]}, 32'(1 + i / 3));
    for (int i = 1; i < 24; i++) chk("t1_spacing", beat_t[i] - beat_t[i-1], 4);

    // Test 2: single sample, div=2, osr=2 -> repeat with underrun counting
    src[0] = 16'h1234;
    restart(16'd2, 16'd2, 1);
    cyc();
    chk("t2_flag_cleared", {31'd0, underrun}, 32'd0);
    chk("t2_cnt_cleared", {16'd0, ucnt}, 32'd0);
    collect("t2_b3", 3, 40);
    chk("t2_cnt_after3", {16'd0, ucnt}, 32'd1);
    collect("t2_b8", 8, 40);
    chk("t2_underrun", {31'd0, underrun}, 32'd1);
    chk("t2_cnt_after8", {16'd0, ucnt}, 32'd4);
    for (int i = 0; i < 8; i++) chk("t2_data", {16'd0, beat_d[i]}, 32'h1234);
    for (int i = 1; i < 8; i++) chk("t2_spacing", beat_t[i] - beat_t[i-1], 2);

    // Test 3: div=0, osr=0 behave as 1/1
    for (int i = 0; i < 5; i++) src[i] = 16'(16'h000A + i);
    restart(16'd0, 16'd0, 5);
    collect("t3_b5", 5, 30);
    for (int i = 0; i < 5; i++) chk("t3_data", {16'd0, beat_d[i]}, 32'(10 + i));
    for (int i = 1; i < 5; i++) chk("t3_spacing", beat_t[i] - beat_t[i-1], 1);

    // Test 4: modulator stalls 10 cycles with div=2
    src[0] = 16'h0100;
    src[1] = 16'h0200;
    restart(16'd2, 16'd4, 2);
    wait_valid("t4_first_beat", 30, n);
    chk("t4_late_before", {31'd0, late}, 32'd0);
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t4_hold_valid", {31'd0, m_tvalid}, 32'd1);
      chk("t4_hold_data", {16'd0, m_tdata}, 32'h0100);
    end
    chk("t4_late", {31'd0, late}, 32'd1);
    m_tready = 1'b1;
    collect("t4_b8", 8, 80);
    for (int i = 0; i < 8; i++) chk("t4_data", {16'd0, beat_d[i]}, (i < 4) ? 32'h0100 : 32'h0200);

    // Test 5: FIFO fills during RUN (div=4, osr=4)
    for (int i = 0; i < 6; i++) src[i] = 16'(16'h0011 + i);
    restart(16'd4, 16'd4, 6);
    for (int i = 0; i < 10; i++) cyc();
    chk("t5_full_tready", {31'd0, s_tready}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) cyc();
    chk("t5_still_full", {31'd0, s_tready}, 32'd0);
    cyc();
    chk("t5_after_pop", {31'd0, s_tready}, 32'd1);
    collect("t5_b24", 24, 250);
    for (int i = 0; i < 24; i++) chk("t5_order", {16'd0, beat_d[i]}, 32'(17 + i / 4));

    // Test 6a: enable dropped mid-beat
    for (int i = 0; i < 4; i++) src[i] = 16'(16'h0021 + i);
    restart(16'd2, 16'd8, 4);
    wait_valid("t6a_first_beat", 30, n);
    m_tready   = 1'b0;
    cfg_enable = 1'b0;
    cyc();
    chk("t6a_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t6a_busy", {31'd0, busy}, 32'd0);
    chk("t6a_s_tready", {31'd0, s_tready}, 32'd0);
    src_n = src_idx;
    drive_src();
    m_tready   = 1'b1;
    cfg_enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_tvalid) seen++;
    end
    chk("t6a_fifo_empty", seen, 0);
    chk("t6a_priming", {31'd0, busy}, 32'd1);

    // Test 6b: arst pulsed mid-RUN clears sticky state
    src[0] = 16'h0055;
    restart(16'd2, 16'd1, 1);
    wait_valid("t6b_first_beat", 30, n);
    chk("t6b_underrun", {31'd0, underrun}, 32'd1);
    chk("t6b_ucnt", {16'd0, ucnt}, 32'd1);
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t6b_late", {31'd0, late}, 32'd1);
    arst = 1'b1;
    cyc();
    chk("t6b_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t6b_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6b_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("t6b_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("t6b_rst_ucnt", {16'd0, ucnt}, 32'd0);
    chk("t6b_rst_late", {31'd0, late}, 32'd0);
    chk("t6b_rst_tdata", {16'd0, m_tdata}, 32'd0);
    arst     = 1'b0;
    m_tready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m_tvalid) seen++;
    end
    chk("t6b_fifo_empty", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsm_sample_scheduler.md
# dsm_sample_scheduler

Rate scheduler that sits in front of the second-order delta-sigma modulator and sequences its input. It buffers low-rate PCM samples from an upstream AXI-Stream source. Each buffered sample is zero-order-held and presented to the modulator as `OSR` update beats, spaced by a programmable clock-divider tick. On starvation the current sample is repeated and the event is counted, so the modulator never sees a gap in its update cadence.

## Interface
Parameters:
- `WIDTH`, 16: sample width, signed two's complement.
- `DIV_WIDTH`, 16: width of `cfg_div`.
- `OSR_WIDTH`, 16: width of `cfg_osr`.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.

Ports:
- `aclk`, in, 1: clock; the only clock.
- `arst`, in, 1: reset; synchronous, active-high.
- `cfg_enable`, in, 1: run request.
- `cfg_div`, in, DIV_WIDTH: `aclk` cycles between update beats; 0 treated as 1.
- `cfg_osr`, in, OSR_WIDTH: beats per input sample; 0 treated as 1.
- `s_axis_data_tdata`, in, WIDTH: upstream sample.
- `s_axis_data_tvalid`, in, 1: upstream valid.
- `s_axis_data_tready`, out, 1: FIFO can accept.
- `m_axis_data_tdata`, out, WIDTH: sample to modulator.
- `m_axis_data_tvalid`, out, 1: update beat pending.
- `m_axis_data_tready`, in, 1: modulator accepts beat.
- `busy`, out, 1: state ≠ IDLE.
- `underrun`, out, 1: sticky; a held sample was repeated past `OSR` beats.
- `underrun_cnt`, out, 16: underrun events, saturating at 0xFFFF.
- `late`, out, 1: sticky; a tick fired while the previous beat was still unaccepted.

## Operation
- Reset values: `s_axis_data_tready`=0, `m_axis_data_tdata`=0, `m_axis_data_tvalid`=0, `busy`=0, `underrun`=0, `underrun_cnt`=0, `late`=0. State=IDLE, FIFO empty, all counters 0.
- FIFO: synchronous, with no fall-through.
  - Write when `tvalid && tready`; `s_axis_data_tready` = busy && !full (registered from occupancy).
  - A simultaneous write and read at non-empty, non-full occupancy keeps the count unchanged.
  - A read while empty is not performed; a same-cycle write to an empty FIFO is not visible to the read.
- States:
  - IDLE:
    - FIFO held flushed; `tready`=0; `m_axis_data_tvalid`=0; hold register = 0, which is midscale and gives 50% density.
    - `cfg_enable`=1 → PRIME.
    - On this transition: latch `cfg_div` and `cfg_osr` (0 mapped to 1); clear `underrun`, `underrun_cnt` and `late`.
  - PRIME:
    - Wait for the FIFO to be non-empty, then pop the head into the hold register and go to RUN.
    - Clear the divider counter and the beat counter.
  - RUN:
    - The divider counter counts 0..div−1. A tick is asserted on the cycle the count equals div−1; the counter then wraps to 0.
    - On a tick, if no beat is pending: set `m_axis_data_tvalid`=1 with `m_axis_data_tdata`=hold, and increment the beat counter.
    - On a tick with a beat still pending: the tick is dropped and the beat counter is not advanced. Set `late`. The data of the pending beat does not change while `tvalid`=1.
    - A beat clears when `m_axis_data_tvalid && m_axis_data_tready`.
    - When the beat counter reaches osr on a tick, it resets to 0 and the hold register is reloaded for the next tick:
      - FIFO non-empty: pop into hold.
      - FIFO empty: keep hold, set `underrun`, and increment `underrun_cnt` (saturating).
- `cfg_enable`=0 in any state → IDLE on the next cycle. Any pending beat is dropped (`tvalid`→0), the FIFO is flushed, and hold→0.
- The config inputs are ignored outside the IDLE→PRIME transition.
- `arst` overrides everything, in any state, including mid-beat.

## Timing
- All outputs are registered.
- `cfg_enable` rising at cycle E gives PRIME at E+1.
- PRIME with a non-empty FIFO at cycle P gives the pop at P and RUN at P+1.
- First tick is at RUN entry + div−1; `m_axis_data_tvalid` rises on the following cycle.
- With the modulator always ready, beats occur every div cycles; div=1 gives a beat every cycle.
- The beat carrying a new sample is the first beat after the osr-th beat of the previous sample.
- An underrun is detected on the tick that completes the osr-th beat of a sample.
- Sustained throughput without underrun requires an input rate ≥ 1/(div·osr) samples per cycle.

## Test plan
- Ramp of samples 0x0001..0x0008 fed faster than the drain rate, modulator ready, div=4, osr=3 → each value appears on exactly 3 beats, beats are spaced 4 cycles, and `underrun`=0.
- Single sample 0x1234, div=2, osr=2, no further input → after 2 beats, 0x1234 continues to repeat. `underrun`=1 and `underrun_cnt` increments once per 2 beats.
- `cfg_div`=0, `cfg_osr`=0 → behaves as div=1, osr=1: one beat per cycle, each a new FIFO sample.
- `m_axis_data_tready` held 0 for 10 cycles with div=2 → `tvalid` and data stay stable, `late`=1, and the beat count advances only on acceptance.
- FIFO filled to `FIFO_DEPTH` while in RUN → `s_axis_data_tready`=0 until a pop, no sample is lost or duplicated, and the order is preserved.
- `cfg_enable` dropped mid-beat, and separately `arst` pulsed mid-RUN → next cycle `tvalid`=0, `busy`=0 and the FIFO is empty; `arst` additionally clears all sticky flags and `underrun_cnt`.
